// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP output chain: frame constants, the serializer
// state encoding and the frame byte selector.
package dsp_pkg;

   localparam logic [7:0] FRAME_HDR   = 8'hA5;
   localparam int         FRAME_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   // Byte idx of the frame for a zero-extended 16-bit sample: HDR, HI, LO, HI^LO.
   function automatic logic [7:0] frame_byte(input logic [15:0] sample, input logic [1:0] idx);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = sample[15:8];
      lo = sample[7:0];
      case (idx)
         2'd0:    return FRAME_HDR;
         2'd1:    return hi;
         2'd2:    return lo;
         default: return hi ^ lo;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A load while idle, or on the final stop-bit cycle,
// starts the next start bit on the following cycle so bytes run back to back.
module uart_tx_byte
   import dsp_pkg::*;
#(
   parameter int clk_per_bit = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_done
);

   localparam int                BAUD_W    = (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clk_per_bit - 1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic              w_tx_nxt;
   logic              w_tick;
   logic              w_accept;

   assign w_tick   = (r_baud == BAUD_LAST);
   assign o_done   = (r_state == STOP) && w_tick;
   assign w_accept = i_load && ((r_state == IDLE) || o_done);
   assign o_tx     = r_tx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      case (r_state)
         IDLE: begin
            if (i_load) begin
               w_state_nxt = START;
               w_tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nxt = DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_tx_nxt    = r_shift[1];
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_nxt = i_load ? START : IDLE;
               w_tx_nxt    = !i_load;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   // The baud counter is held at zero while idle so every byte starts on a bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud <= '0;
         r_bit  <= '0;
      end else begin
         if (r_state == IDLE || w_tick) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + 1'b1;
         end
         if (r_state != DATA) begin
            r_bit <= '0;
         end else if (w_tick) begin
            r_bit <= r_bit + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_shift <= i_byte;
      end else if (r_state == DATA && w_tick) begin
         r_shift <= r_shift >> 1;
      end
   end

endmodule

// File: rtl/avg_uart_tx.sv
// Frames each averaged sample as A5/HI/LO/CHK and sends it over an 8N1 line,
// with a one-entry holding register between sample arrival and the serializer.
module avg_uart_tx
   import dsp_pkg::*;
#(
   parameter int datlen      = 12,
   parameter int clk_per_bit = 868
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [0:datlen-1] avg,
   input  logic              avg_valid,
   output logic              tx,
   output logic              busy,
   output logic              overrun
);

   localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

   logic [15:0] w_avg16;
   logic [15:0] r_active;
   logic [15:0] r_hold;
   logic        r_hold_full;
   logic [1:0]  r_idx;
   logic        r_busy;
   logic        r_overrun;

   logic        w_done;
   logic        w_load;
   logic [7:0]  w_byte;
   logic        w_take_avg;
   logic        w_take_hold;
   logic        w_hold_wr;
   logic        w_hold_clr;
   logic        w_drop;
   logic [1:0]  w_idx_nxt;
   logic        w_busy_nxt;

   assign w_avg16 = 16'(avg);
   assign busy    = r_busy;
   assign overrun = r_overrun;

   uart_tx_byte #(
      .clk_per_bit(clk_per_bit)
   ) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .i_load(w_load),
      .i_byte(w_byte),
      .o_tx  (tx),
      .o_done(w_done)
   );

   // At frame end the slot being vacated is free again, so an arrival in that
   // same cycle is never dropped: it either follows the held sample or starts directly.
   always_comb begin
      w_load      = 1'b0;
      w_byte      = FRAME_HDR;
      w_take_avg  = 1'b0;
      w_take_hold = 1'b0;
      w_hold_wr   = 1'b0;
      w_hold_clr  = 1'b0;
      w_drop      = 1'b0;
      w_idx_nxt   = r_idx;
      w_busy_nxt  = r_busy;
      if (w_done) begin
         if (r_idx != LAST_IDX) begin
            w_load    = 1'b1;
            w_byte    = frame_byte(r_active, r_idx + 2'd1);
            w_idx_nxt = r_idx + 2'd1;
            if (avg_valid) begin
               w_hold_wr = !r_hold_full;
               w_drop    = r_hold_full;
            end
         end else if (r_hold_full) begin
            w_load      = 1'b1;
            w_take_hold = 1'b1;
            w_idx_nxt   = '0;
            w_hold_wr   = avg_valid;
            w_hold_clr  = !avg_valid;
         end else if (avg_valid) begin
            w_load     = 1'b1;
            w_take_avg = 1'b1;
            w_idx_nxt  = '0;
         end else begin
            w_busy_nxt = 1'b0;
            w_idx_nxt  = '0;
         end
      end else if (avg_valid) begin
         if (!r_busy) begin
            w_load     = 1'b1;
            w_take_avg = 1'b1;
            w_idx_nxt  = '0;
            w_busy_nxt = 1'b1;
         end else if (!r_hold_full) begin
            w_hold_wr = 1'b1;
         end else begin
            w_drop    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy      <= 1'b0;
         r_idx       <= '0;
         r_hold_full <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_idx     <= w_idx_nxt;
         r_overrun <= w_drop;
         if (w_hold_wr) begin
            r_hold_full <= 1'b1;
         end else if (w_hold_clr) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_take_avg) begin
         r_active <= w_avg16;
      end else if (w_take_hold) begin
         r_active <= r_hold;
      end
      if (w_hold_wr) begin
         r_hold <= w_avg16;
      end
   end

endmodule

// File: tb/tb_avg_uart_tx.sv
// Bench for avg_uart_tx: a bit-stream queue model checked every cycle, plus
// hand-computed frame decodes for the directed scenarios and a random phase.
module tb_avg_uart_tx;

   localparam int DATLEN    = 12;
   localparam int CPB       = 4;
   localparam int BYTE_CYC  = 10 * CPB;
   localparam int FRAME_CYC = 4 * BYTE_CYC;
   localparam int LOG_N     = 16384;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [11:0] avg       = '0;
   logic        avg_valid = 1'b0;
   logic        tx;
   logic        busy;
   logic        overrun;

   avg_uart_tx #(
      .datlen     (DATLEN),
      .clk_per_bit(CPB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .avg      (avg),
      .avg_valid(avg_valid),
      .tx       (tx),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic tx_log   [LOG_N];
   logic busy_log [LOG_N];
   logic ov_log   [LOG_N];

   // Model: expected line level per future cycle, plus the one-deep wait slot.
   bit          mq[$];
   logic [11:0] mhold[$];
   bit          m_ov = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_frame(input logic [11:0] v);
      logic [7:0] b [4];
      bit         lvl;
      b[0] = 8'hA5;
      b[1] = {4'h0, v[11:8]};
      b[2] = v[7:0];
      b[3] = b[1] ^ b[2];
      for (int k = 0; k < 4; k++)
         for (int p = 0; p < 10; p++) begin
            lvl = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[k][p-1];
            for (int r = 0; r < CPB; r++) mq.push_back(lvl);
         end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mhold.delete();
         m_ov = 1'b0;
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         m_ov = 1'b0;
         if (mq.size() == 0 && mhold.size() > 0) push_frame(mhold.pop_front());
         if (avg_valid) begin
            if (mq.size() == 0)         push_frame(avg);
            else if (mhold.size() == 0) mhold.push_back(avg);
            else                        m_ov = 1'b1;
         end
      end
   end

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         tx_log[cyc]   = tx;
         busy_log[cyc] = busy;
         ov_log[cyc]   = overrun;
      end
      if (rst_n) begin
         chk("tx_vs_model", 32'(tx), (mq.size() > 0) ? 32'(mq[0]) : 32'd1);
         chk("busy_vs_model", 32'(busy), 32'(mq.size() > 0));
         chk("overrun_vs_model", 32'(overrun), 32'(m_ov));
      end
   end

   // Returns {stop, data[7:0], start} sampled one cycle into each bit.
   function automatic logic [9:0] dec10(input int s);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = tx_log[s + CPB * i + 1];
      return r;
   endfunction

   task automatic check_frame(input string name, input int s, input logic [31:0] bytes);
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = bytes[31 - 8 * k -: 8];
         chk(name, 32'(dec10(s + k * BYTE_CYC)), 32'({1'b1, b, 1'b0}));
      end
   endtask

   function automatic int count_ov(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (ov_log[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int busy_all(input int a, input int b);
      for (int i = a; i <= b; i++) if (busy_log[i] !== 1'b1) return 0;
      return 1;
   endfunction

   // Called right after a negedge; returns the cycle index of the first frame cycle.
   task automatic strobe(input logic [11:0] v, output int s);
      avg       = v;
      avg_valid = 1'b1;
      @(posedge clk);
      #1 s = cyc;
      @(negedge clk);
      avg_valid = 1'b0;
   endtask

   task automatic wait_cyc(input string name, input int target);
      for (int g = 0; g < 2000 && cyc != target; g++) @(negedge clk);
      if (cyc != target) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: wait ended at cycle %0d, wanted %0d", name, cyc, target);
      end
   endtask

   int s, s2, s3, c0, ok_tx, ok_busy;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      strobe(12'hABC, s);
      repeat (170) @(negedge clk);
      check_frame("single_frame", s, 32'hA50ABCB6);
      chk("single_busy_before", 32'(busy_log[s-1]), 32'd0);
      chk("single_start_tx", 32'(tx_log[s]), 32'd0);
      chk("single_busy_last", 32'(busy_log[s+FRAME_CYC-1]), 32'd1);
      chk("single_busy_fall", 32'(busy_log[s+FRAME_CYC]), 32'd0);
      chk("single_no_overrun", 32'(count_ov(s, s + 169)), 32'd0);

      strobe(12'h123, s);
      repeat (9) @(negedge clk);
      strobe(12'h456, s2);
      repeat (330) @(negedge clk);
      check_frame("b2b_first", s, 32'hA5012322);
      check_frame("b2b_second", s + FRAME_CYC, 32'hA5045652);
      chk("b2b_busy_continuous", 32'(busy_all(s, s + 2 * FRAME_CYC - 1)), 32'd1);
      chk("b2b_busy_fall", 32'(busy_log[s+2*FRAME_CYC]), 32'd0);

      strobe(12'h001, s);
      strobe(12'h002, s2);
      strobe(12'h003, s3);
      repeat (330) @(negedge clk);
      check_frame("ovr_first", s, 32'hA5000101);
      check_frame("ovr_second", s + FRAME_CYC, 32'hA5000202);
      chk("ovr_pulse", 32'(ov_log[s3]), 32'd1);
      chk("ovr_pulse_count", 32'(count_ov(s, s + 329)), 32'd1);
      chk("ovr_idle_after", 32'(busy_log[s+2*FRAME_CYC]), 32'd0);

      strobe(12'h5A3, s);
      repeat (5) @(negedge clk);
      strobe(12'h0F0, s2);
      wait_cyc("simul_align", s + FRAME_CYC - 1);
      strobe(12'h777, s3);
      repeat (500) @(negedge clk);
      check_frame("simul_first", s, 32'hA505A3A6);
      check_frame("simul_held", s + FRAME_CYC, 32'hA500F0F0);
      check_frame("simul_new", s + 2 * FRAME_CYC, 32'hA5077770);
      chk("simul_no_overrun", 32'(count_ov(s, s + 499)), 32'd0);
      chk("simul_busy_continuous", 32'(busy_all(s, s + 3 * FRAME_CYC - 1)), 32'd1);
      chk("simul_busy_fall", 32'(busy_log[s+3*FRAME_CYC]), 32'd0);

      strobe(12'h300, s);
      wait_cyc("midreset_align", s + 2 * BYTE_CYC + 10);
      chk("midreset_pre_tx", 32'(tx), 32'd0);
      chk("midreset_pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_tx", 32'(tx), 32'd1);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_overrun", 32'(overrun), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      strobe(12'hFFF, s);
      repeat (170) @(negedge clk);
      check_frame("midreset_recover", s, 32'hA50FFFF0);
      chk("midreset_recover_fall", 32'(busy_log[s+FRAME_CYC]), 32'd0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      repeat (1000) @(negedge clk);
      ok_tx   = 1;
      ok_busy = 1;
      for (int i = c0 + 1; i < c0 + 1000; i++) begin
         if (tx_log[i] !== 1'b1)   ok_tx   = 0;
         if (busy_log[i] !== 1'b0) ok_busy = 0;
      end
      chk("idle_tx_high", 32'(ok_tx), 32'd1);
      chk("idle_busy_low", 32'(ok_busy), 32'd0 + 32'd1);

      for (int i = 0; i < 2000; i++) begin
         avg_valid = ($urandom_range(0, 39) == 0);
         avg       = 12'($urandom);
         @(negedge clk);
      end
      for (int i = 0; i < 1500; i++) begin
         avg_valid = ($urandom_range(0, 5) == 0);
         avg       = 12'($urandom);
         @(negedge clk);
      end
      avg_valid = 1'b0;
      repeat (400) @(negedge clk);
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_tx", 32'(tx), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/avg_uart_tx.md
# avg_uart_tx

Serial output stage of the DSP chain: consumes each averaged sample produced by the signal-averaging stage and transmits it off-chip over an 8N1 UART line as a fixed 4-byte frame (header, high byte, low byte, checksum). A one-entry holding register decouples sample arrival from transmission. Overflow is reported when a new sample arrives with both the frame and the holding register occupied.

## Interface
- `datlen`, 12: width of the averaged sample; legal range 9..16.
- `clk_per_bit`, 868: clock cycles per UART bit (baud divisor); must be ≥ 2.
- `clk` input 1: system clock; all logic rises on `clk`.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `avg` input [0:datlen-1]: averaged sample; index 0 is the MSB.
- `avg_valid` input 1: single-cycle strobe, synchronous to `clk`; `avg` is valid while it is high.
- `tx` output 1: UART line; idles high.
- `busy` output 1: high while a frame is on the line.
- `overrun` output 1: one-cycle pulse when a sample is dropped.

## Operation
- **Frame layout.** Bytes are sent in order: 0xA5, HI, LO, CHK.
  - HI = sample bits above the low 8, zero-padded to 8 bits.
  - LO = low 8 bits of the sample.
  - CHK = HI xor LO.
- **Byte format.** Start bit 0, 8 data bits LSB first, 1 stop bit 1. Bytes within a frame are contiguous, with no idle gap.
- **Storage.**
  - Active register: holds the frame being sent.
  - Holding register: one entry, with a full flag.
- **Accepting a sample.** On `avg_valid`:
  - If idle and holding is empty: load the active register and start a frame.
  - Else if holding is empty: load holding.
  - Else: drop the new sample (holding is kept) and pulse `overrun`.
- **Frame end.** When the last stop bit completes:
  - If holding is full: move it to the active register and start the next start bit on the following cycle.
  - Else: go to IDLE.
- **Simultaneous events.** `avg_valid` in the same cycle as frame end with holding full: holding transfers to the active register and the new sample enters holding. Nothing is dropped and `overrun` stays 0.
- **State machine.** States are IDLE, START, DATA, STOP.
  - IDLE → START on an accepted sample.
  - START → DATA after `clk_per_bit` cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → START when the byte index < 3 (index increments), or when index = 3 and holding is full.
  - STOP → IDLE otherwise.
- **Counters.**
  - Baud counter: 0..clk_per_bit-1, wraps at the terminal count.
  - Bit counter: 0..7.
  - Byte index: 0..3.
- **Reset.** Asserting `rst_n` low at any time, including mid-frame, gives:
  - `tx`=1, `busy`=0, `overrun`=0;
  - state IDLE, all counters 0, holding empty.
  - A partially sent frame is abandoned.

## Timing
- **Start latency.** `avg_valid` sampled high at edge N while idle gives `tx`=0 and `busy`=1 from edge N+1.
- **Frame length.** Each bit is exactly `clk_per_bit` cycles. A frame is 40·`clk_per_bit` cycles.
- **Busy.** `busy` falls on the cycle after the last stop bit ends, unless a queued frame starts. With back-to-back frames, `busy` stays high continuously.
- **Overrun.** `overrun` is high for exactly the one cycle after the dropping edge.
- **Minimum spacing.** Samples arriving no closer than 40·`clk_per_bit` cycles apart never overrun.
- **Outputs.** `tx`, `busy` and `overrun` are registered; there are no combinational paths from the inputs.

## Structure
- **Shared package `dsp_pkg`:**
  - `FRAME_HDR` = 8'hA5;
  - `FRAME_BYTES` = 4;
  - the state enum (IDLE, START, DATA, STOP).
- **Sub-module `uart_tx_byte`:**
  - Serializes one byte and owns the baud and bit counters.
  - Interface: `load`/`byte` in, `done` pulse out.
  - The top level keeps the frame sequencer, holding register and checksum.

## Test plan
All scenarios use `clk_per_bit`=4 and `datlen`=12.
- **Single frame.** Reset, then `avg`=12'hABC strobed once → `tx` carries bytes A5, 0A, BC, B6 LSB-first with 4-cycle bits. Frame is 160 cycles. `busy` falls at cycle 161. `overrun` is never asserted.
- **Back-to-back.** Strobe 12'h123, then 12'h456 ten cycles later → two frames with no idle gap: 0xA5 01 23 22, then 0xA5 04 56 52. `busy` stays continuously high.
- **Overrun.** Strobe 12'h001, 12'h002, 12'h003 within the first 20 cycles → frames for 001 and 002 only. One `overrun` pulse, one cycle after the third strobe.
- **Simultaneous event.** Holding full and a strobe on the final stop-bit cycle → the held sample is sent next, the new sample follows, `overrun`=0.
- **Reset mid-frame.** Assert `rst_n`=0 during the LO byte → `tx`=1 and `busy`=0 immediately (asynchronous). After release, strobe 12'hFFF → a clean frame A5 0F FF F0.
- **Idle line.** No strobes for 1000 cycles after reset → `tx` is constant 1 and `busy`=0.
